accum_mem_port: RTL and testbench
=================================

// Module: accum_mem_port
// PURPOSE
//  Memory-side counterpart of the accumulator register. STORE: snapshots accum_out and writes it to data memory.
//  LOAD: reads data memory and drives data/load_acc into the accumulator for exactly one cycle.
//  Sits between the control unit (cmd handshake) and the data-memory req/ack port.
// PARAMETERS
//  ADDR_W   8   data-memory address width
//  TIMEOUT  16  max REQ cycles without mem_ack before abort; legal range >=1; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  cmd_valid  in   1       command request from control unit
//  cmd_ready  out  1       high only in IDLE; command accepted when cmd_valid & cmd_ready
//  cmd_op     in   1       0 = LOAD (mem->accum), 1 = STORE (accum->mem)
//  cmd_addr   in   ADDR_W  memory address for the command
//  accum_out  in   16      current accumulator value (STORE source)
//  data       out  16      value for accumulator input (LOAD result)
//  load_acc   out  1       one-cycle strobe: accumulator loads data
//  mem_req    out  1       memory request, held until ack or timeout
//  mem_we     out  1       1 = write, 0 = read; valid while mem_req
//  mem_addr   out  ADDR_W  memory address; valid while mem_req
//  mem_wdata  out  16      write data; valid while mem_req & mem_we
//  mem_rdata  in   16      read data; sampled in the mem_ack cycle
//  mem_ack    in   1       memory completion, single cycle
//  busy       out  1       high in every state except IDLE (= ~cmd_ready)
//  err        out  1       sticky timeout flag
//  err_clr    in   1       synchronous clear of err
// BEHAVIOUR
//  Reset values: state=IDLE, cmd_ready=1, busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, data=0, load_acc=0, err=0, timeout count=0.
//  rst asserted mid-operation clears everything at once. mem_req drops without waiting for the clock. No load_acc is issued.
//  All outputs are registered. No combinational path from any input to any output.
//  States: IDLE, REQ, LOAD.
//  IDLE: cmd_ready=1. On accept at edge T, latch op->mem_we, cmd_addr->mem_addr, count=0.
//    For STORE, also latch accum_out->mem_wdata (snapshot of the accept cycle; later accumulator changes are ignored).
//    Next state is REQ, so mem_req is high from cycle T+1.
//  REQ: mem_req, mem_we, mem_addr and mem_wdata are held stable. count increments on each REQ cycle without ack.
//    mem_ack & STORE: mem_req=0, next state IDLE.
//    mem_ack & LOAD: data<=mem_rdata, mem_req=0, next state LOAD.
//    No ack and count==TIMEOUT-1: err<=1, mem_req=0, next state IDLE. data is unchanged and no load_acc is issued.
//    mem_ack in the final timeout cycle: ack wins and err is not set.
//  LOAD: load_acc=1 for exactly one cycle with data valid. Next state IDLE.
//  Minimum latency, counted from the accept edge T with ack in the first REQ cycle:
//    STORE: cmd_ready returns at T+2.
//    LOAD: load_acc is high at T+2 and cmd_ready returns at T+3.
//  data holds the last loaded value until the next successful LOAD or reset.
//  mem_ack outside REQ is ignored. A new command cannot be accepted while busy (cmd_ready=0).
//  err_clr clears err. If err_clr and a timeout occur in the same cycle, err ends set.
//  err does not block new commands.
// TESTING
//  STORE: accum_out=16'hA5C3 and accept cmd_op=1, cmd_addr=8'h10; accum_out changes to 16'h0000 on the next cycle; ack after 3 REQ cycles
//    -> mem_req high 3 cycles, mem_we=1, mem_addr=8'h10, mem_wdata=16'hA5C3 throughout; busy falls after the ack.
//  LOAD: cmd_op=0, cmd_addr=8'h22, mem_rdata=16'h1234 with ack in the first REQ cycle
//    -> load_acc high for exactly 1 cycle at T+2 with data=16'h1234; cmd_ready=1 at T+3.
//  Timeout, TIMEOUT=4, LOAD with no ack -> mem_req high exactly 4 cycles, err=1, no load_acc, data unchanged.
//    Then pulse err_clr -> err=0.
//  Tie: TIMEOUT=4 with ack in the 4th REQ cycle -> transfer completes normally and err stays 0.
//  Reset mid-REQ of a LOAD -> mem_req=0 and all outputs at reset values with no clock edge; no load_acc follows.
//  Back-to-back: cmd_valid held high for STORE then LOAD -> second command accepted only once cmd_ready=1;
//    stray mem_ack in IDLE is ignored.

Source files
------------

// File: rtl/accum_mem_port.sv
// accum_mem_port
//   Memory-side companion of the accumulator register. A STORE command
//   snapshots the accumulator value and writes it to data memory. A LOAD
//   command reads data memory and presents the word on data_o, with a
//   one-cycle load_acc_o strobe for the accumulator.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   cmd_*           command handshake from the control unit
//                   (cmd_op_i: 0 = LOAD, 1 = STORE)
//   accum_out_i     current accumulator value (STORE source)
//   data_o          LOAD result, held until the next successful LOAD
//   load_acc_o      one-cycle strobe: the accumulator takes data_o
//   mem_*           request/acknowledge data-memory port
//   busy_o          high whenever a command is in flight
//   err_o/err_clr_i sticky timeout flag and its synchronous clear
//
// Every output comes straight from a flop, so no input reaches an output
// combinationally.
module accum_mem_port #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [15:0]       accum_out_i,
  output logic [15:0]       data_o,
  output logic              load_acc_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_wdata_o,
  input  logic [15:0]       mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              busy_o,
  output logic              err_o,
  input  logic              err_clr_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t              state_q;
  logic                cmd_ready_q;
  logic                busy_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [15:0]         mem_wdata_q;
  logic [15:0]         data_q;
  logic                load_acc_q;
  logic                err_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;

  assign count_d = count_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      data_q      <= '0;
      load_acc_q  <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      // Strobe defaults low; only the REQ->LOAD transition raises it.
      load_acc_q <= 1'b0;
      // A timeout later in this block overrides the clear, so a
      // simultaneous timeout leaves err set.
      if (err_clr_i) begin
        err_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_q) begin
            mem_we_q   <= cmd_op_i;
            mem_addr_q <= cmd_addr_i;
            // Snapshot taken on the accept edge; later accumulator
            // changes do not disturb the write data.
            if (cmd_op_i) begin
              mem_wdata_q <= accum_out_i;
            end
            count_q     <= '0;
            mem_req_q   <= 1'b1;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= REQ;
          end
        end

        REQ: begin
          // Ack is checked first so an ack in the last allowed cycle
          // completes the transfer instead of timing out.
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            if (mem_we_q) begin
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
            end else begin
              data_q     <= mem_rdata_i;
              load_acc_q <= 1'b1;
              state_q    <= LOAD;
            end
          end else if (count_q == CNT_LAST) begin
            err_q       <= 1'b1;
            mem_req_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            count_q <= count_d;
          end
        end

        LOAD: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end

        default: begin
          mem_req_q   <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = busy_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign data_o      = data_q;
  assign load_acc_o  = load_acc_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_accum_mem_port.sv
// tb_accum_mem_port
//   Directed bench for accum_mem_port with TIMEOUT=4. Each task drives one
//   scenario and compares outputs against hand-computed values, sampling
//   1 ns after the rising edge.
module tb_accum_mem_port;

  logic        clk;
  logic        rst;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_op_i;
  logic [7:0]  cmd_addr_i;
  logic [15:0] accum_out_i;
  logic [15:0] data_o;
  logic        load_acc_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [7:0]  mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic [15:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        busy_o;
  logic        err_o;
  logic        err_clr_i;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Packed view of every output; reset value is cmd_ready=1, all else 0.
  wire [45:0] out_vec = {cmd_ready_o, busy_o, mem_req_o, mem_we_o, mem_addr_o,
                         mem_wdata_o, data_o, load_acc_o, err_o};
  localparam logic [45:0] RST_VEC = {1'b1, 45'b0};

  accum_mem_port #(.ADDR_W(8), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_addr_i  (cmd_addr_i),
    .accum_out_i (accum_out_i),
    .data_o      (data_o),
    .load_acc_o  (load_acc_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .err_clr_i   (err_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    total_cnt++;
    if (out_vec !== RST_VEC) $display("FAIL reset_outputs: got %h want %h", out_vec, RST_VEC);
    else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++;
    if (out_vec !== RST_VEC) $display("FAIL idle_after_reset: got %h want %h", out_vec, RST_VEC);
    else pass_cnt++;
    $display("reset: outputs at reset values");
  endtask

  task automatic test_store();
    accum_out_i = 16'hA5C3; cmd_op_i = 1'b1; cmd_addr_i = 8'h10; cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0; accum_out_i = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, cmd_ready_o} !==
          {1'b1, 1'b1, 8'h10, 16'hA5C3, 1'b1, 1'b0})
        $display("FAIL store_req_cyc%0d: req=%b we=%b addr=%h wdata=%h busy=%b rdy=%b want 1 1 10 a5c3 1 0",
                 i, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, cmd_ready_o);
      else pass_cnt++;
      if (i == 2) mem_ack_i = 1'b1;
      step();
    end
    mem_ack_i = 1'b0;
    total_cnt++;
    if ({mem_req_o, busy_o, cmd_ready_o, load_acc_o} !== 4'b0010)
      $display("FAIL store_done: req=%b busy=%b rdy=%b ld=%b want 0 0 1 0",
               mem_req_o, busy_o, cmd_ready_o, load_acc_o);
    else pass_cnt++;
    $display("store: addr=10 wdata=a5c3 ack after 3 req cycles");
  endtask

  task automatic test_load();
    cmd_op_i = 1'b0; cmd_addr_i = 8'h22; mem_rdata_i = 16'h1234; cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    total_cnt++;
    if ({mem_req_o, mem_we_o, mem_addr_o, load_acc_o} !== {1'b1, 1'b0, 8'h22, 1'b0})
      $display("FAIL load_req: req=%b we=%b addr=%h ld=%b want 1 0 22 0",
               mem_req_o, mem_we_o, mem_addr_o, load_acc_o);
    else pass_cnt++;
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0; mem_rdata_i = 16'h0000;
    total_cnt++;
    if ({load_acc_o, data_o, mem_req_o, cmd_ready_o} !== {1'b1, 16'h1234, 1'b0, 1'b0})
      $display("FAIL load_strobe_t2: ld=%b data=%h req=%b rdy=%b want 1 1234 0 0",
               load_acc_o, data_o, mem_req_o, cmd_ready_o);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({load_acc_o, data_o, cmd_ready_o, busy_o} !== {1'b0, 16'h1234, 1'b1, 1'b0})
      $display("FAIL load_done_t3: ld=%b data=%h rdy=%b busy=%b want 0 1234 1 0",
               load_acc_o, data_o, cmd_ready_o, busy_o);
    else pass_cnt++;
    $display("load: addr=22 rdata=1234 ack in first req cycle");
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int ld_seen = 0;
    cmd_op_i = 1'b0; cmd_addr_i = 8'h33; mem_rdata_i = 16'hFFFF; cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mem_req_o) req_cycles++;
      if (load_acc_o) ld_seen++;
      step();
    end
    total_cnt++;
    if (req_cycles != 4) $display("FAIL timeout_req_len: got %0d cycles want 4", req_cycles);
    else pass_cnt++;
    total_cnt++;
    if ({err_o, data_o, cmd_ready_o} !== {1'b1, 16'h1234, 1'b1} || ld_seen != 0)
      $display("FAIL timeout_state: err=%b data=%h rdy=%b ld_seen=%0d want 1 1234 1 0",
               err_o, data_o, cmd_ready_o, ld_seen);
    else pass_cnt++;
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    total_cnt++;
    if (err_o !== 1'b0) $display("FAIL err_clr: got %b want 0", err_o);
    else pass_cnt++;
    $display("timeout: load addr=33 no ack, err set then cleared");

    // err_clr coinciding with the timeout cycle leaves err set.
    cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    step(); step(); step();
    total_cnt++;
    if ({mem_req_o, err_o} !== 2'b10) $display("FAIL timeout_last_cyc: req=%b err=%b want 1 0", mem_req_o, err_o);
    else pass_cnt++;
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    total_cnt++;
    if ({err_o, mem_req_o} !== 2'b10) $display("FAIL clr_vs_timeout: err=%b req=%b want 1 0", err_o, mem_req_o);
    else pass_cnt++;
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    total_cnt++;
    if (err_o !== 1'b0) $display("FAIL err_clr2: got %b want 0", err_o);
    else pass_cnt++;
    $display("timeout: err_clr with timeout, err set");
  endtask

  task automatic test_tie();
    cmd_op_i = 1'b0; cmd_addr_i = 8'h44; mem_rdata_i = 16'hBEEF; cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    step(); step(); step();
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    total_cnt++;
    if ({err_o, load_acc_o, data_o, mem_req_o} !== {1'b0, 1'b1, 16'hBEEF, 1'b0})
      $display("FAIL tie_ack_wins: err=%b ld=%b data=%h req=%b want 0 1 beef 0",
               err_o, load_acc_o, data_o, mem_req_o);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({cmd_ready_o, load_acc_o, err_o} !== 3'b100)
      $display("FAIL tie_done: rdy=%b ld=%b err=%b want 1 0 0", cmd_ready_o, load_acc_o, err_o);
    else pass_cnt++;
    $display("tie: load addr=44 ack in 4th req cycle");
  endtask

  task automatic test_reset_mid();
    int ld_seen = 0;
    cmd_op_i = 1'b0; cmd_addr_i = 8'h55; mem_rdata_i = 16'h7777; cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    step();
    total_cnt++;
    if (mem_req_o !== 1'b1) $display("FAIL rst_mid_pre: req=%b want 1", mem_req_o);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (out_vec !== RST_VEC) $display("FAIL rst_async: got %h want %h", out_vec, RST_VEC);
    else pass_cnt++;
    mem_ack_i = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (load_acc_o) ld_seen++;
      if (i == 0) mem_ack_i = 1'b0;
      step();
    end
    total_cnt++;
    if (out_vec !== RST_VEC || ld_seen != 0)
      $display("FAIL rst_no_load: got %h ld_seen=%0d want %h 0", out_vec, ld_seen, RST_VEC);
    else pass_cnt++;
    $display("reset_mid: load addr=55 aborted by reset");
  endtask

  task automatic test_back_to_back();
    accum_out_i = 16'h1111; cmd_op_i = 1'b1; cmd_addr_i = 8'h60; cmd_valid_i = 1'b1;
    step();
    cmd_op_i = 1'b0; cmd_addr_i = 8'h61;
    total_cnt++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, cmd_ready_o} !== {1'b1, 1'b1, 8'h60, 16'h1111, 1'b0})
      $display("FAIL b2b_store_req: req=%b we=%b addr=%h wdata=%h rdy=%b want 1 1 60 1111 0",
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, cmd_ready_o);
    else pass_cnt++;
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    total_cnt++;
    if ({cmd_ready_o, mem_req_o} !== 2'b10)
      $display("FAIL b2b_idle_gap: rdy=%b req=%b want 1 0", cmd_ready_o, mem_req_o);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({mem_req_o, mem_we_o, mem_addr_o, cmd_ready_o} !== {1'b1, 1'b0, 8'h61, 1'b0})
      $display("FAIL b2b_load_req: req=%b we=%b addr=%h rdy=%b want 1 0 61 0",
               mem_req_o, mem_we_o, mem_addr_o, cmd_ready_o);
    else pass_cnt++;
    cmd_valid_i = 1'b0; mem_rdata_i = 16'h5678; mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    total_cnt++;
    if ({load_acc_o, data_o} !== {1'b1, 16'h5678})
      $display("FAIL b2b_load_data: ld=%b data=%h want 1 5678", load_acc_o, data_o);
    else pass_cnt++;
    step();
    mem_rdata_i = 16'h9999; mem_ack_i = 1'b1;
    step(); step();
    mem_ack_i = 1'b0;
    total_cnt++;
    if ({mem_req_o, busy_o, load_acc_o, data_o, cmd_ready_o} !== {1'b0, 1'b0, 1'b0, 16'h5678, 1'b1})
      $display("FAIL stray_ack: req=%b busy=%b ld=%b data=%h rdy=%b want 0 0 0 5678 1",
               mem_req_o, busy_o, load_acc_o, data_o, cmd_ready_o);
    else pass_cnt++;
    $display("back_to_back: store addr=60 then load addr=61, stray ack ignored");
  endtask

  initial begin
    rst = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = 1'b0; cmd_addr_i = 8'h00;
    accum_out_i = 16'h0000; mem_rdata_i = 16'h0000; mem_ack_i = 1'b0; err_clr_i = 1'b0;
    test_reset();
    test_store();
    test_load();
    test_timeout();
    test_tie();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
